// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: priority-resolves hazard, branch, multi-cycle and
// memory-wait requests into pipeline-register controls. Macro STALL_PERF_CNT_EN builds the counters.
module pipeline_stall_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_stop,
    input  logic             br_flush,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             ex_mem_bubble,
    output logic             mem_wb_write,
    output logic             mc_busy,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          stall_inc;
    logic          flush_inc;
    logic          go_busy;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_bubble = 1'b0;
        mem_wb_write  = 1'b1;
        mc_busy       = (state == MC_BUSY);
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        go_busy       = 1'b0;

        // A memory wait freezes every register regardless of state.
        if (mem_wait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            stall_inc    = 1'b1;
        end else if (state == RUN) begin
            if (br_flush) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                flush_inc    = 1'b1;
            end else if (mc_start && !mc_done) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
                stall_inc     = 1'b1;
                go_busy       = 1'b1;
            end else if (!mc_start && hz_stop) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_inc    = 1'b1;
            end
        end else if (!mc_done) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            stall_inc     = 1'b1;
        end

        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b0;
            ex_mem_write  = 1'b0;
            ex_mem_bubble = 1'b0;
            mem_wb_write  = 1'b0;
            mc_busy       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            timer  <= '0;
            mc_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (go_busy) begin
                        state <= MC_BUSY;
                        timer <= '0;
                    end
                end
                MC_BUSY: begin
                    // The watchdog only counts cycles the EX unit itself is holding the pipe.
                    if (!mem_wait) begin
                        if (mc_done) begin
                            state <= RUN;
                        end else begin
                            timer <= timer + TW'(1);
                            if (timer == TIMER_LAST) begin
                                mc_err <= 1'b1;
                                state  <= RUN;
                            end
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_inc;
    assign unused_inc = stall_inc ^ flush_inc;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: a default-parameter instance plus a short-timeout,
// narrow-counter instance sharing the same stimulus.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, hz_stop, br_flush, mc_start, mc_done, mem_wait;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic ex_mem_write, ex_mem_bubble, mem_wb_write, mc_busy, mc_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic to_pc_write, to_if_id_write, to_if_id_flush, to_id_ex_write, to_id_ex_bubble;
    logic to_ex_mem_write, to_ex_mem_bubble, to_mem_wb_write, to_mc_busy, to_mc_err;
    logic [2:0] to_stall_cnt, to_flush_cnt;

    pipeline_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hz_stop(hz_stop), .br_flush(br_flush),
        .mc_start(mc_start), .mc_done(mc_done), .mem_wait(mem_wait),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
        .ex_mem_write(ex_mem_write), .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_write(mem_wb_write), .mc_busy(mc_busy), .mc_err(mc_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_stall_ctrl #(.MC_TIMEOUT(4), .CNT_W(3)) dut_to (
        .clk(clk), .rst_n(rst_n), .hz_stop(hz_stop), .br_flush(br_flush),
        .mc_start(mc_start), .mc_done(mc_done), .mem_wait(mem_wait),
        .pc_write(to_pc_write), .if_id_write(to_if_id_write), .if_id_flush(to_if_id_flush),
        .id_ex_write(to_id_ex_write), .id_ex_bubble(to_id_ex_bubble),
        .ex_mem_write(to_ex_mem_write), .ex_mem_bubble(to_ex_mem_bubble),
        .mem_wb_write(to_mem_wb_write), .mc_busy(to_mc_busy), .mc_err(to_mc_err),
        .stall_cnt(to_stall_cnt), .flush_cnt(to_flush_cnt)
    );

    // Control vector order: pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, ex_mem_bubble, mem_wb_w, mc_busy
    localparam logic [8:0] V_DEF  = 9'b110101010;
    localparam logic [8:0] V_HZ   = 9'b000111010;
    localparam logic [8:0] V_BR   = 9'b111111010;
    localparam logic [8:0] V_MEMW = 9'b000000000;
    localparam logic [8:0] V_MCS  = 9'b000001110;
    localparam logic [8:0] V_BSY  = 9'b000001111;
    localparam logic [8:0] V_BWT  = 9'b000000001;
    localparam logic [8:0] V_BDN  = 9'b110101011;
    localparam logic [8:0] V_RST  = 9'b000000000;

    int tests = 0;
    int fails = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [8:0] exp_q[$];
    logic [8:0] to_q[$];

    function automatic logic [8:0] dut_vec();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                ex_mem_write, ex_mem_bubble, mem_wb_write, mc_busy};
    endfunction

    function automatic logic [8:0] to_vec();
        return {to_pc_write, to_if_id_write, to_if_id_flush, to_id_ex_write, to_id_ex_bubble,
                to_ex_mem_write, to_ex_mem_bubble, to_mem_wb_write, to_mc_busy};
    endfunction

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef STALL_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [2:0] sat3_exp(input int v);
`ifdef STALL_PERF_CNT_EN
        return (v > 7) ? 3'd7 : 3'(v);
`else
        return 3'd0;
`endif
    endfunction

    // Scoreboard: control outputs are compared mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            tests++;
            if (dut_vec() !== e) begin
                fails++;
                $display("FAIL ctrl t=%0t got %b want %b", $time, dut_vec(), e);
            end
        end
        if (to_q.size() > 0) begin
            logic [8:0] e;
            e = to_q.pop_front();
            tests++;
            if (to_vec() !== e) begin
                fails++;
                $display("FAIL to_ctrl t=%0t got %b want %b", $time, to_vec(), e);
            end
        end
    end

    task automatic drive(input logic h, input logic b, input logic s, input logic d,
                         input logic m, input logic [8:0] e, input int st, input int fl);
        hz_stop  = h;
        br_flush = b;
        mc_start = s;
        mc_done  = d;
        mem_wait = m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        exp_stall += st;
        exp_flush += fl;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        hz_stop  = 1'b0;
        br_flush = 1'b0;
        mc_start = 1'b0;
        mc_done  = 1'b0;
        mem_wait = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        hz_stop  = 1'b0;
        br_flush = 1'b0;
        mc_start = 1'b0;
        mc_done  = 1'b0;
        mem_wait = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (dut_vec() !== V_RST) begin
            fails++;
            $display("FAIL reset_ctrl got %b want %b", dut_vec(), V_RST);
        end
        tests++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mc_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs got %0d/%0d/%b want 0/0/0", stall_cnt, flush_cnt, mc_err);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, V_DEF, 0, 0);
        drive(0, 0, 0, 0, 0, V_DEF, 0, 0);
        tests++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL idle_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_hz_stop();
        apply_reset();
        drive(1, 0, 0, 0, 0, V_HZ, 1, 0);
        tests++;
        if (stall_cnt !== cnt_exp(exp_stall)) begin
            fails++;
            $display("FAIL hz_stall_cnt got %0d want %0d", stall_cnt, cnt_exp(exp_stall));
        end
        drive(0, 0, 0, 0, 0, V_DEF, 0, 0);
    endtask

    task automatic test_flush_priority();
        apply_reset();
        drive(1, 1, 1, 0, 0, V_BR, 0, 1);
        drive(0, 0, 0, 0, 0, V_DEF, 0, 0);
        tests++;
        if (flush_cnt !== cnt_exp(exp_flush) || stall_cnt !== cnt_exp(exp_stall)) begin
            fails++;
            $display("FAIL flush_cnts got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt,
                     cnt_exp(exp_flush), cnt_exp(exp_stall));
        end
        drive(1, 1, 1, 0, 1, V_MEMW, 1, 0);
        drive(0, 0, 1, 1, 0, V_DEF, 0, 0);
        drive(0, 0, 0, 0, 0, V_DEF, 0, 0);
        tests++;
        if (flush_cnt !== cnt_exp(exp_flush) || stall_cnt !== cnt_exp(exp_stall)) begin
            fails++;
            $display("FAIL memw_cnts got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt,
                     cnt_exp(exp_flush), cnt_exp(exp_stall));
        end
    endtask

    task automatic test_mc_wait();
        apply_reset();
        drive(0, 0, 1, 0, 0, V_MCS, 1, 0);
        drive(0, 0, 0, 0, 0, V_BSY, 1, 0);
        drive(0, 0, 0, 0, 1, V_BWT, 1, 0);
        drive(1, 1, 0, 0, 0, V_BSY, 1, 0);
        drive(0, 0, 1, 0, 0, V_BSY, 1, 0);
        drive(0, 0, 0, 0, 0, V_BSY, 1, 0);
        drive(0, 0, 0, 1, 0, V_BDN, 0, 0);
        drive(0, 0, 0, 0, 0, V_DEF, 0, 0);
        tests++;
        if (stall_cnt !== cnt_exp(exp_stall) || flush_cnt !== cnt_exp(exp_flush)) begin
            fails++;
            $display("FAIL mc_cnts got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                     cnt_exp(exp_stall), cnt_exp(exp_flush));
        end
        tests++;
        if (mc_err !== 1'b0) begin
            fails++;
            $display("FAIL mc_err_clear got %b want 0", mc_err);
        end
    endtask

    task automatic test_random_run();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            logic h, b, m;
            logic [8:0] e;
            m = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 2) == 0);
            h = ($urandom_range(0, 1) == 1);
            e = m ? V_MEMW : (b ? V_BR : (h ? V_HZ : V_DEF));
            drive(h, b, 0, 0, m, e, (m || (!b && h)) ? 1 : 0, (!m && b) ? 1 : 0);
        end
        tests++;
        if (stall_cnt !== cnt_exp(exp_stall) || flush_cnt !== cnt_exp(exp_flush)) begin
            fails++;
            $display("FAIL rand_cnts got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                     cnt_exp(exp_stall), cnt_exp(exp_flush));
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, V_HZ, 1, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0, V_BR, 0, 1);
        tests++;
        if (to_stall_cnt !== sat3_exp(exp_stall) || to_flush_cnt !== sat3_exp(exp_flush)) begin
            fails++;
            $display("FAIL sat_cnts got %0d/%0d want %0d/%0d", to_stall_cnt, to_flush_cnt,
                     sat3_exp(exp_stall), sat3_exp(exp_flush));
        end
        tests++;
        if (stall_cnt !== cnt_exp(exp_stall) || flush_cnt !== cnt_exp(exp_flush)) begin
            fails++;
            $display("FAIL wide_cnts got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                     cnt_exp(exp_stall), cnt_exp(exp_flush));
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        mc_start = 1'b1;
        to_q.push_back(V_MCS);
        @(posedge clk);
        #1;
        mc_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            mem_wait = (i == 2);
            to_q.push_back((i == 2) ? V_BWT : V_BSY);
            @(posedge clk);
            #1;
            tests++;
            if (to_mc_err !== (i == 5)) begin
                fails++;
                $display("FAIL to_err_cycle%0d got %b want %b", i, to_mc_err, (i == 5));
            end
        end
        mem_wait = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_q.push_back(V_DEF);
            @(posedge clk);
            #1;
            tests++;
            if (to_mc_err !== 1'b1) begin
                fails++;
                $display("FAIL to_err_sticky got %b want 1", to_mc_err);
            end
        end
        apply_reset();
        tests++;
        if (to_mc_err !== 1'b0 || mc_err !== 1'b0) begin
            fails++;
            $display("FAIL to_err_reset got %b/%b want 0/0", to_mc_err, mc_err);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(0, 0, 1, 0, 0, V_MCS, 1, 0);
        drive(0, 0, 0, 0, 0, V_BSY, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (dut_vec() !== V_RST) begin
            fails++;
            $display("FAIL async_ctrl got %b want %b", dut_vec(), V_RST);
        end
        tests++;
        if (stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL async_cnt got %0d want 0", stall_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, V_DEF, 0, 0);
        drive(1, 0, 0, 0, 0, V_HZ, 1, 0);
        tests++;
        if (stall_cnt !== cnt_exp(exp_stall)) begin
            fails++;
            $display("FAIL async_after got %0d want %0d", stall_cnt, cnt_exp(exp_stall));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_hz_stop();
        test_flush_priority();
        test_mc_wait();
        test_random_run();
        test_saturation();
        test_timeout();
        test_async_reset();
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0 || to_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d/%0d want 0/0", exp_q.size(), to_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
